// File: rtl/pc_unit.sv
// Program-counter / fetch sequencer: sequential, branch, jump, jr, eret, exception/irq redirect with EPC,
// HALT state and retired-instruction counter. Define PC_MISALIGN_TRAP_EN to trap misaligned jr targets.
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch,
  input  logic             jr,
  input  logic             eret,
  input  logic             halt,
  input  logic             exc,
  input  logic             irq,
  input  logic [31:0]      imm,
  input  logic [25:0]      ins_addr,
  input  logic [31:0]      rs_val,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      epc,
  output logic             halted,
  output logic             exc_taken,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  localparam logic [1:0] CAUSE_EXC      = 2'd0;
  localparam logic [1:0] CAUSE_IRQ      = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      epc_q, epc_d;
  logic             exc_taken_q, exc_taken_d;
  logic [1:0]       exc_cause_q, exc_cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [31:0] br_target, j_target, jr_target;
  logic        jr_trap;

  // Offset high bits are redundant sign copies; jr low bits only matter when trapping.
  logic unused_bits;
  assign unused_bits = ^{imm[31:30], rs_val[1:0]};

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ins_addr, 2'b00};
  assign jr_target = {rs_val[31:2], 2'b00};

`ifdef PC_MISALIGN_TRAP_EN
  // jr is only "selected" when no higher-priority eret is present.
  assign jr_trap = jr && !eret && (rs_val[1:0] != 2'b00);
`else
  assign jr_trap = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    exc_taken_d = 1'b0;
    exc_cause_d = exc_cause_q;
    instret_d   = instret_q;

    unique case (state_q)
      ST_RUN: begin
        if (exc || irq) begin
          epc_d       = pc_q;
          pc_d        = EXC_VECTOR;
          exc_taken_d = 1'b1;
          exc_cause_d = exc ? CAUSE_EXC : CAUSE_IRQ;
        end else if (stall) begin
          // hold everything; controller re-presents the request
        end else if (jr_trap) begin
          epc_d       = pc_q;
          pc_d        = EXC_VECTOR;
          exc_taken_d = 1'b1;
          exc_cause_d = CAUSE_MISALIGN;
        end else begin
          instret_d = instret_q + 1'b1;
          if (eret)        pc_d = epc_q;
          else if (jr)     pc_d = jr_target;
          else if (jump)   pc_d = j_target;
          else if (branch) pc_d = br_target;
          else begin
            pc_d = pc_plus4;
            if (halt) state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (irq) begin
          epc_d       = pc_q;
          pc_d        = EXC_VECTOR;
          exc_taken_d = 1'b1;
          exc_cause_d = CAUSE_IRQ;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_VECTOR;
      epc_q       <= 32'd0;
      exc_taken_q <= 1'b0;
      exc_cause_q <= 2'd0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      exc_taken_q <= exc_taken_d;
      exc_cause_q <= exc_cause_d;
      instret_q   <= instret_d;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign halted    = (state_q == ST_HALT);
  assign exc_taken = exc_taken_q;
  assign exc_cause = exc_cause_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: each driven cycle pushes its expected architectural state,
// popped and compared one clock later.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, jump, branch, jr, eret, halt, exc, irq;
  logic [31:0] imm, rs_val;
  logic [25:0] ins_addr;
  logic [31:0] pc, pc_plus4, epc, instret;
  logic        halted, exc_taken;
  logic [1:0]  exc_cause;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        halted;
    logic        exc_taken;
    logic [1:0]  cause;
    logic [31:0] instret;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .branch(branch), .jr(jr),
    .eret(eret), .halt(halt), .exc(exc), .irq(irq), .imm(imm), .ins_addr(ins_addr),
    .rs_val(rs_val), .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .halted(halted),
    .exc_taken(exc_taken), .exc_cause(exc_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    stall = 0; jump = 0; branch = 0; jr = 0; eret = 0; halt = 0; exc = 0; irq = 0;
    imm = '0; rs_val = '0; ins_addr = '0;
  endtask

  task automatic check_all(input string tag, input exp_t x);
    check({tag, ".pc"},        pc,                  x.pc);
    check({tag, ".pc_plus4"},  pc_plus4,            x.pc + 32'd4);
    check({tag, ".epc"},       epc,                 x.epc);
    check({tag, ".halted"},    {31'd0, halted},     {31'd0, x.halted});
    check({tag, ".exc_taken"}, {31'd0, exc_taken},  {31'd0, x.exc_taken});
    check({tag, ".cause"},     {30'd0, exc_cause},  {30'd0, x.cause});
    check({tag, ".instret"},   instret,             x.instret);
  endtask

  // Inputs are already driven; push expectation, clock once, compare, then clear inputs.
  task automatic step(input string tag, input exp_t x);
    exp_t got_e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    check_all(tag, got_e);
    clr();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #12;
    e = '{pc: 32'h0, epc: 32'h0, halted: 1'b0, exc_taken: 1'b0, cause: 2'd0, instret: 32'd0};
    check_all("reset", e);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Sequential fetch after reset
    for (int i = 1; i <= 3; i++) begin
      e.pc = 32'(i * 4); e.instret++;
      step("seq", e);
    end

    // Branch with negative offset, then jump keeping pc_plus4[31:28]
    jr = 1; rs_val = 32'h100;           e.pc = 32'h100;       e.instret++; step("jr_to_100", e);
    branch = 1; imm = 32'hFFFF_FFFE;    e.pc = 32'h0FC;       e.instret++; step("branch_neg", e);
    jr = 1; rs_val = 32'h1000_0010;     e.pc = 32'h1000_0010; e.instret++; step("jr_to_hi", e);
    jump = 1; ins_addr = 26'h40;        e.pc = 32'h1000_0100; e.instret++; step("jump", e);

    // Priority: jump over branch, jr over jump
    jump = 1; ins_addr = 26'h10; branch = 1; imm = 32'h1;
    e.pc = 32'h1000_0040; e.instret++; step("jump_over_branch", e);
    jr = 1; rs_val = 32'h20; jump = 1; ins_addr = 26'h3FF;
    e.pc = 32'h20; e.instret++; step("jr_over_jump", e);

    // Stall holds pc/instret for two cycles, then the jump goes through
    for (int i = 0; i < 2; i++) begin
      stall = 1; jump = 1; ins_addr = 26'h30;
      step("stall_hold", e);
    end
    jump = 1; ins_addr = 26'h30; e.pc = 32'hC0; e.instret++; step("after_stall", e);

    // Exception beats stall; eret returns to faulting pc
    jr = 1; rs_val = 32'h40; e.pc = 32'h40; e.instret++; step("jr_to_40", e);
    exc = 1; stall = 1;
    e.epc = 32'h40; e.pc = 32'h80; e.exc_taken = 1; e.cause = 2'd0; step("exc_stall", e);
    eret = 1; e.pc = 32'h40; e.exc_taken = 0; e.instret++; step("eret", e);

    // Back-to-back irq keeps exc_taken high; cause held afterwards
    irq = 1; e.epc = 32'h40; e.pc = 32'h80; e.exc_taken = 1; e.cause = 2'd1; step("irq1", e);
    irq = 1; e.epc = 32'h80; step("irq2", e);
    e.pc = 32'h84; e.exc_taken = 0; e.instret++; step("after_irq", e);

    // HALT: retire, freeze, ignore requests, leave on irq
    jr = 1; rs_val = 32'h60; e.pc = 32'h60; e.instret++; step("jr_to_60", e);
    halt = 1; e.pc = 32'h64; e.halted = 1; e.instret++; step("halt", e);
    jump = 1; ins_addr = 26'h99; exc = 1; stall = 1; branch = 1; halt = 1;
    step("halt_ignore", e);
    irq = 1; e.pc = 32'h80; e.epc = 32'h64; e.halted = 0; e.exc_taken = 1; e.cause = 2'd1;
    step("halt_irq", e);
    e.pc = 32'h84; e.exc_taken = 0; e.instret++; step("run_again", e);

    // Halt combined with a redirect: redirect wins, no HALT
    halt = 1; jump = 1; ins_addr = 26'h50; e.pc = 32'h140; e.instret++; step("halt_redirect", e);

    // Misaligned jr
    jr = 1; rs_val = 32'h202;
`ifdef PC_MISALIGN_TRAP_EN
    e.epc = 32'h140; e.pc = 32'h80; e.exc_taken = 1; e.cause = 2'd2;
`else
    e.pc = 32'h200; e.instret++;
`endif
    step("jr_misaligned", e);

    // Wrap-around of pc
    jr = 1; rs_val = 32'hFFFF_FFFC; e.pc = 32'hFFFF_FFFC; e.exc_taken = 0; e.instret++;
    step("jr_to_top", e);
    e.pc = 32'h0; e.instret++; step("pc_wrap", e);

    // Asynchronous reset mid-cycle
    jump = 1; ins_addr = 26'h77;
    #2;
    rst = 1'b1;
    #1;
    e = '{pc: 32'h0, epc: 32'h0, halted: 1'b0, exc_taken: 1'b0, cause: 2'd0, instret: 32'd0};
    check_all("async_rst", e);
    clr();
    @(negedge clk);
    rst = 1'b0;
    #1;
    e.pc = 32'h4; e.instret = 32'd1; step("post_rst_seq", e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
